// File: rtl/router_reg_if.sv
// router_reg_if: byte datapath, FSM strobes and status between the router FSM/source and router_reg.
interface router_reg_if #(parameter int DW = 8);
  logic [DW-1:0] data_in;
  logic [DW-1:0] dout;
  logic pkt_valid;
  logic fifo_full;
  logic rst_int_reg;
  logic detect_add;
  logic ld_state;
  logic laf_state;
  logic full_state;
  logic lfd_state;
  logic parity_done;
  logic low_pkt_valid;
  logic err;
  modport master (
    output data_in, pkt_valid, fifo_full, rst_int_reg, detect_add,
           ld_state, laf_state, full_state, lfd_state,
    input  dout, parity_done, low_pkt_valid, err
  );
  modport slave (
    input  data_in, pkt_valid, fifo_full, rst_int_reg, detect_add,
           ld_state, laf_state, full_state, lfd_state,
    output dout, parity_done, low_pkt_valid, err
  );
endinterface

// File: rtl/router_reg.sv
// router_reg: header latch, byte staging to fifo, full-byte parking and XOR parity check.
module router_reg #(parameter int DW = 8) (
  input logic   clk,
  input logic   reset,
  router_reg_if.slave bus
);
  logic [DW-1:0] hdr_byte, full_byte, int_par, pkt_par;
  logic chk, lfd, ld, laf;
  // one-hot strobes resolved by priority detect_add > lfd > ld > laf
  assign lfd = bus.lfd_state & !bus.detect_add;
  assign ld  = bus.ld_state & !bus.detect_add & !bus.lfd_state;
  assign laf = bus.laf_state & !bus.detect_add & !bus.lfd_state & !bus.ld_state;
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dout          <= '0;
      hdr_byte          <= '0;
      full_byte         <= '0;
      int_par           <= '0;
      pkt_par           <= '0;
      bus.parity_done   <= 1'b0;
      bus.low_pkt_valid <= 1'b0;
      bus.err           <= 1'b0;
      chk               <= 1'b0;
    end else begin
      if (bus.detect_add && bus.pkt_valid && bus.data_in[1:0] != 2'b11)
        hdr_byte <= bus.data_in;
      if (lfd)
        bus.dout <= hdr_byte;
      else if (ld && !bus.fifo_full)
        bus.dout <= bus.data_in;
      else if (ld)
        full_byte <= bus.data_in;
      else if (laf)
        bus.dout <= full_byte;
      // a parked payload byte is folded into parity when it is finally released
      if (bus.detect_add)
        int_par <= '0;
      else if (lfd)
        int_par <= int_par ^ hdr_byte;
      else if (ld && bus.pkt_valid && !bus.full_state && !bus.fifo_full)
        int_par <= int_par ^ bus.data_in;
      else if (laf && !bus.low_pkt_valid)
        int_par <= int_par ^ full_byte;
      if (bus.rst_int_reg)
        bus.low_pkt_valid <= 1'b0;
      else if (ld && !bus.pkt_valid)
        bus.low_pkt_valid <= 1'b1;
      if (bus.detect_add) begin
        bus.parity_done <= 1'b0;
      end else if (ld && !bus.pkt_valid && !bus.fifo_full) begin
        bus.parity_done <= 1'b1;
        pkt_par         <= bus.data_in;
      end else if (laf && bus.low_pkt_valid && !bus.parity_done) begin
        bus.parity_done <= 1'b1;
        pkt_par         <= full_byte;
      end
      if (bus.detect_add) begin
        bus.err <= 1'b0;
        chk     <= 1'b0;
      end else if (bus.parity_done && !chk) begin
        bus.err <= (int_par != pkt_par);
        chk     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: directed packet vectors against hand-computed bytes and parity.
module tb_router_reg;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_pass = 0;
  router_reg_if #(.DW(8)) bus ();
  router_reg #(.DW(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.detect_add = 0; bus.lfd_state = 0; bus.ld_state = 0; bus.laf_state = 0;
    bus.full_state = 0; bus.rst_int_reg = 0; bus.fifo_full = 0; bus.pkt_valid = 0;
    bus.data_in = 8'h00;
  endtask
  function automatic logic [7:0] pay(input int i);
    return 8'(8'hC3 ^ (i * 8'h1D));
  endfunction
  task automatic header(input logic [7:0] hdr);
    idle();
    bus.detect_add = 1; bus.pkt_valid = 1; bus.data_in = hdr;
    tick();
    bus.detect_add = 0;
  endtask
  task automatic pkt(input logic [7:0] hdr, input logic [7:0] flip, input string tag);
    logic [7:0] par;
    int n;
    n = int'(hdr[7:2]);
    par = hdr;
    header(hdr);
    check({tag, "_arm_pd"}, 8'(bus.parity_done), 8'h00);
    bus.lfd_state = 1;
    tick();
    check({tag, "_hdr"}, bus.dout, hdr);
    bus.lfd_state = 0; bus.ld_state = 1;
    for (int i = 0; i < n; i++) begin
      bus.data_in = pay(i);
      par ^= pay(i);
      tick();
      if (bus.dout !== pay(i)) check({tag, "_pay"}, bus.dout, pay(i));
    end
    check({tag, "_last_pay"}, bus.dout, pay(n - 1));
    bus.pkt_valid = 0; bus.data_in = par ^ flip;
    tick();
    check({tag, "_par_byte"}, bus.dout, par ^ flip);
    check({tag, "_pd"}, 8'(bus.parity_done), 8'h01);
    check({tag, "_lpv"}, 8'(bus.low_pkt_valid), 8'h01);
    bus.ld_state = 0;
    tick();
    check({tag, "_err"}, 8'(bus.err), (flip != 0) ? 8'h01 : 8'h00);
    bus.rst_int_reg = 1;
    tick();
    check({tag, "_lpv_clr"}, 8'(bus.low_pkt_valid), 8'h00);
    bus.rst_int_reg = 0;
  endtask
  initial begin
    // 1: reset with everything asserted
    reset = 1;
    bus.data_in = 8'hFF; bus.pkt_valid = 1; bus.fifo_full = 1; bus.rst_int_reg = 1;
    bus.detect_add = 1; bus.lfd_state = 1; bus.ld_state = 1; bus.laf_state = 1;
    bus.full_state = 1;
    tick(); tick();
    check("rst_dout", bus.dout, 8'h00);
    check("rst_pd", 8'(bus.parity_done), 8'h00);
    check("rst_lpv", 8'(bus.low_pkt_valid), 8'h00);
    check("rst_err", 8'(bus.err), 8'h00);
    reset = 0;
    idle();
    tick();
    // 2: good packet; 3: corrupted parity
    pkt(8'h39, 8'h00, "good");
    pkt(8'h39, 8'h01, "bad");
    idle();
    tick(); tick(); tick();
    check("err_hold", 8'(bus.err), 8'h01);
    // 5: addr 11 header ignored, also clears err
    header(8'h3B);
    check("err_clr", 8'(bus.err), 8'h00);
    bus.lfd_state = 1;
    tick();
    check("addr3_hdr", bus.dout, 8'h39);
    // 4: fifo full on payload A5; parity 09^3C^A5 = 90
    header(8'h09);
    bus.lfd_state = 1;
    tick();
    check("ff_hdr", bus.dout, 8'h09);
    bus.lfd_state = 0; bus.ld_state = 1; bus.data_in = 8'h3C;
    tick();
    check("ff_p0", bus.dout, 8'h3C);
    bus.data_in = 8'hA5; bus.fifo_full = 1;
    tick();
    check("ff_hold", bus.dout, 8'h3C);
    bus.ld_state = 0; bus.full_state = 1; bus.data_in = 8'h00;
    tick(); tick(); tick();
    check("ff_full_hold", bus.dout, 8'h3C);
    bus.full_state = 0; bus.fifo_full = 0; bus.laf_state = 1;
    tick();
    check("ff_laf", bus.dout, 8'hA5);
    check("ff_laf_pd", 8'(bus.parity_done), 8'h00);
    bus.laf_state = 0; bus.ld_state = 1; bus.pkt_valid = 0; bus.data_in = 8'h90;
    tick();
    check("ff_par", bus.dout, 8'h90);
    check("ff_pd", 8'(bus.parity_done), 8'h01);
    bus.ld_state = 0;
    tick();
    check("ff_err", 8'(bus.err), 8'h00);
    // 6: reset mid-packet, then fresh packet
    header(8'h15);
    bus.lfd_state = 1;
    tick();
    bus.lfd_state = 0; bus.ld_state = 1;
    for (int i = 0; i < 5; i++) begin
      bus.data_in = pay(i);
      tick();
    end
    reset = 1;
    tick();
    check("mid_rst_dout", bus.dout, 8'h00);
    check("mid_rst_lpv", 8'(bus.low_pkt_valid), 8'h00);
    reset = 0;
    idle();
    tick();
    pkt(8'h0A, 8'h00, "post_rst");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
